// File: rtl/a_wr_scheduler.sv
// Issue-side A-register write scheduler: reserves destinations, rejects result-slot
// collisions at issue, and replays each accepted write on the A-register file port.
module a_wr_scheduler #(
  parameter int NREG = 8,
  parameter int AW   = 3,
  parameter int SRCW = 4,
  parameter int MAXD = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_issue,
  input  logic            i_a_dest_en,
  input  logic [AW-1:0]   i_dest,
  input  logic [3:0]      i_delay,
  input  logic [SRCW-1:0] i_src,
  input  logic            i_clear,
  output logic            o_stall,
  output logic [NREG-1:0] o_busy,
  output logic            o_wr_en,
  output logic [AW-1:0]   o_wr_addr,
  output logic [SRCW-1:0] o_wr_src
);

  logic [MAXD-1:0] valid_q, valid_d;
  logic [AW-1:0]   addr_q [MAXD];
  logic [AW-1:0]   addr_d [MAXD];
  logic [SRCW-1:0] src_q  [MAXD];
  logic [SRCW-1:0] src_d  [MAXD];
  logic [NREG-1:0] busy_q, busy_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [SRCW-1:0] wr_src_q, wr_src_d;

  logic            request;
  logic            accept;
  logic [MAXD:0]   valid_ext;
  logic [3:0]      slot_idx;

  // The extra top bit stands in for the nonexistent slot[MAXD], which is never occupied.
  assign valid_ext = {1'b0, valid_q};
  assign request   = i_issue && i_a_dest_en && (i_delay != 4'd0);
  assign o_stall   = !i_clear && request && (busy_q[i_dest] || valid_ext[i_delay]);
  assign accept    = request && !o_stall && !i_clear;
  assign slot_idx  = i_delay - 4'd1;

  always_comb begin
    valid_d = '0;
    for (int k = 0; k < MAXD - 1; k++) begin
      valid_d[k] = valid_q[k+1];
      addr_d[k]  = addr_q[k+1];
      src_d[k]   = src_q[k+1];
    end
    addr_d[MAXD-1] = addr_q[MAXD-1];
    src_d[MAXD-1]  = src_q[MAXD-1];

    busy_d = busy_q;
    if (valid_q[0]) begin
      busy_d[addr_q[0]] = 1'b0;
    end

    if (accept) begin
      valid_d[slot_idx] = 1'b1;
      addr_d[slot_idx]  = i_dest;
      src_d[slot_idx]   = i_src;
      busy_d[i_dest]    = 1'b1;
    end

    if (i_clear) begin
      valid_d = '0;
      busy_d  = '0;
    end

    // Write address/source keep their last value between writes.
    wr_addr_d = valid_d[0] ? addr_d[0] : wr_addr_q;
    wr_src_d  = valid_d[0] ? src_d[0]  : wr_src_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= '0;
      busy_q    <= '0;
      wr_addr_q <= '0;
      wr_src_q  <= '0;
      for (int k = 0; k < MAXD; k++) begin
        addr_q[k] <= '0;
        src_q[k]  <= '0;
      end
    end else begin
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      wr_addr_q <= wr_addr_d;
      wr_src_q  <= wr_src_d;
      for (int k = 0; k < MAXD; k++) begin
        addr_q[k] <= addr_d[k];
        src_q[k]  <= src_d[k];
      end
    end
  end

  assign o_busy    = busy_q;
  assign o_wr_en   = valid_q[0];
  assign o_wr_addr = wr_addr_q;
  assign o_wr_src  = wr_src_q;

endmodule

// File: tb/tb_a_wr_scheduler.sv
// Directed bench for a_wr_scheduler: stall, reservation, write timing, flush and reset.
module tb_a_wr_scheduler;

  localparam int NREG = 8;
  localparam int AW   = 3;
  localparam int SRCW = 4;
  localparam int MAXD = 15;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            i_issue;
  logic            i_a_dest_en;
  logic [AW-1:0]   i_dest;
  logic [3:0]      i_delay;
  logic [SRCW-1:0] i_src;
  logic            i_clear;
  logic            o_stall;
  logic [NREG-1:0] o_busy;
  logic            o_wr_en;
  logic [AW-1:0]   o_wr_addr;
  logic [SRCW-1:0] o_wr_src;

  int tests_run    = 0;
  int tests_failed = 0;

  a_wr_scheduler #(.NREG(NREG), .AW(AW), .SRCW(SRCW), .MAXD(MAXD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_issue    (i_issue),
    .i_a_dest_en(i_a_dest_en),
    .i_dest     (i_dest),
    .i_delay    (i_delay),
    .i_src      (i_src),
    .i_clear    (i_clear),
    .o_stall    (o_stall),
    .o_busy     (o_busy),
    .o_wr_en    (o_wr_en),
    .o_wr_addr  (o_wr_addr),
    .o_wr_src   (o_wr_src)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && i_issue && i_a_dest_en && i_delay != 4'd0)
      assert (int'(i_delay) <= MAXD) else $error("delay out of range");
  end

  // Advance to the start of the next cycle; registered outputs are settled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present inputs for the current cycle and let o_stall settle.
  task automatic drive(input logic iss, input logic en, input logic [AW-1:0] d,
                       input logic [3:0] dl, input logic [SRCW-1:0] s);
    i_issue = iss; i_a_dest_en = en; i_dest = d; i_delay = dl; i_src = s;
    #1;
  endtask

  task automatic idle();
    i_issue = 1'b0; i_a_dest_en = 1'b0; i_dest = '0; i_delay = '0; i_src = '0; i_clear = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    #12;
    tests_run++;
    if (o_wr_en !== 1'b0 || o_busy !== 8'h00 || o_wr_addr !== 3'd0 || o_wr_src !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: wr_en=%b busy=%h addr=%0d src=%0d want 0/00/0/0",
               o_wr_en, o_busy, o_wr_addr, o_wr_src);
    end
    drive(1, 1, 3'd4, 4'd3, 4'd1);
    tests_run++;
    if (o_stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_stall: got %b want 0", o_stall);
    end
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    $display("[TB] reset done");
  endtask

  task automatic test_single();
    drive(1, 1, 3'd3, 4'd2, 4'd6);
    tests_run++;
    if (o_stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_stall: got %b want 0", o_stall);
    end
    tick(); idle();
    for (int c = 1; c <= 4; c++) begin
      logic       exp_en;
      logic [7:0] exp_busy;
      exp_en   = (c == 2);
      exp_busy = (c <= 2) ? 8'h08 : 8'h00;
      tests_run++;
      if (o_wr_en !== exp_en || o_busy !== exp_busy || (exp_en && (o_wr_addr !== 3'd3 || o_wr_src !== 4'd6))) begin
        tests_failed++;
        $display("FAIL single_c%0d: wr_en=%b busy=%h addr=%0d src=%0d want %b/%h/3/6",
                 c, o_wr_en, o_busy, o_wr_addr, o_wr_src, exp_en, exp_busy);
      end
      if (c < 4) tick();
    end
    tests_run++;
    if (o_wr_addr !== 3'd3 || o_wr_src !== 4'd6) begin
      tests_failed++;
      $display("FAIL single_hold: addr=%0d src=%0d want 3/6", o_wr_addr, o_wr_src);
    end
    $display("[TB] single issue done");
    tick();
  endtask

  task automatic test_conflict();
    drive(1, 1, 3'd1, 4'd4, 4'd1);
    tests_run++;
    if (o_stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL conflict_first: stall=%b want 0", o_stall);
    end
    tick();
    drive(1, 1, 3'd2, 4'd3, 4'd2);
    tests_run++;
    if (o_stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL conflict_stall: stall=%b want 1", o_stall);
    end
    tick();
    drive(1, 1, 3'd2, 4'd3, 4'd2);
    tests_run++;
    if (o_stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL conflict_retry: stall=%b want 0", o_stall);
    end
    tick(); idle();
    for (int c = 3; c <= 6; c++) begin
      logic       exp_en;
      logic [2:0] exp_addr;
      logic [7:0] exp_busy;
      exp_en   = (c == 4) || (c == 5);
      exp_addr = (c == 4) ? 3'd1 : 3'd2;
      exp_busy = (c <= 4) ? 8'h06 : (c == 5) ? 8'h04 : 8'h00;
      tests_run++;
      if (o_wr_en !== exp_en || o_busy !== exp_busy || (exp_en && (o_wr_addr !== exp_addr || o_wr_src !== 4'(exp_addr)))) begin
        tests_failed++;
        $display("FAIL conflict_c%0d: wr_en=%b busy=%h addr=%0d src=%0d want %b/%h/%0d",
                 c, o_wr_en, o_busy, o_wr_addr, o_wr_src, exp_en, exp_busy, exp_addr);
      end
      if (c < 6) tick();
    end
    $display("[TB] write-slot conflict done");
    tick();
  endtask

  task automatic test_reservation();
    drive(1, 1, 3'd5, 4'd11, 4'd10);
    tick();
    for (int c = 1; c <= 12; c++) begin
      drive(1, 1, 3'd5, 4'd1, 4'd3);
      tests_run++;
      if (o_stall !== (c <= 11) || o_wr_en !== (c == 11) || (c == 11 && o_wr_src !== 4'd10)) begin
        tests_failed++;
        $display("FAIL reserve_c%0d: stall=%b wr_en=%b src=%0d want %b/%b/10",
                 c, o_stall, o_wr_en, o_wr_src, (c <= 11), (c == 11));
      end
      tick();
    end
    idle();
    tests_run++;
    if (o_wr_en !== 1'b1 || o_wr_addr !== 3'd5 || o_wr_src !== 4'd3) begin
      tests_failed++;
      $display("FAIL reserve_write: wr_en=%b addr=%0d src=%0d want 1/5/3", o_wr_en, o_wr_addr, o_wr_src);
    end
    tick();
    tests_run++;
    if (o_wr_en !== 1'b0 || o_busy !== 8'h00) begin
      tests_failed++;
      $display("FAIL reserve_after: wr_en=%b busy=%h want 0/00", o_wr_en, o_busy);
    end
    $display("[TB] destination reservation done");
    tick();
  endtask

  task automatic test_back_to_back();
    drive(1, 1, 3'd0, 4'd1, 4'd1);
    tests_run++;
    if (o_stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_c0_stall: got %b want 0", o_stall);
    end
    tick();
    drive(1, 1, 3'd1, 4'd1, 4'd2);
    tests_run++;
    if (o_stall !== 1'b0 || o_wr_en !== 1'b1 || o_wr_addr !== 3'd0 || o_wr_src !== 4'd1) begin
      tests_failed++;
      $display("FAIL b2b_c1: stall=%b wr_en=%b addr=%0d src=%0d want 0/1/0/1", o_stall, o_wr_en, o_wr_addr, o_wr_src);
    end
    tick();
    drive(1, 1, 3'd2, 4'd6, 4'd4);
    tests_run++;
    if (o_stall !== 1'b0 || o_wr_en !== 1'b1 || o_wr_addr !== 3'd1 || o_wr_src !== 4'd2) begin
      tests_failed++;
      $display("FAIL b2b_c2: stall=%b wr_en=%b addr=%0d src=%0d want 0/1/1/2", o_stall, o_wr_en, o_wr_addr, o_wr_src);
    end
    tick(); idle();
    tests_run++;
    if (o_busy !== 8'h04) begin
      tests_failed++;
      $display("FAIL b2b_busy: got %h want 04", o_busy);
    end
    for (int c = 3; c <= 9; c++) begin
      tests_run++;
      if (o_wr_en !== (c == 8) || (c == 8 && (o_wr_addr !== 3'd2 || o_wr_src !== 4'd4))) begin
        tests_failed++;
        $display("FAIL b2b_c%0d: wr_en=%b addr=%0d src=%0d want %b/2/4", c, o_wr_en, o_wr_addr, o_wr_src, (c == 8));
      end
      if (c < 9) tick();
    end
    $display("[TB] back-to-back done");
    tick();
  endtask

  task automatic test_non_a();
    drive(1, 0, 3'd4, 4'd3, 4'd5);
    tests_run++;
    if (o_stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL nona_stall: got %b want 0", o_stall);
    end
    tick();
    drive(1, 1, 3'd6, 4'd0, 4'd7);
    tests_run++;
    if (o_stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL zerodelay_stall: got %b want 0", o_stall);
    end
    tick(); idle();
    for (int c = 0; c < 16; c++) begin
      tests_run++;
      if (o_wr_en !== 1'b0 || o_busy !== 8'h00) begin
        tests_failed++;
        $display("FAIL nona_c%0d: wr_en=%b busy=%h want 0/00", c, o_wr_en, o_busy);
      end
      tick();
    end
    $display("[TB] non-A and zero-delay done");
  endtask

  task automatic test_flush();
    drive(1, 1, 3'd1, 4'd5, 4'd1); tick();
    drive(1, 1, 3'd2, 4'd6, 4'd2); tick();
    drive(1, 1, 3'd3, 4'd7, 4'd3); tick();
    idle();
    tests_run++;
    if (o_busy !== 8'h0E) begin
      tests_failed++;
      $display("FAIL flush_pre_busy: got %h want 0e", o_busy);
    end
    i_clear = 1'b1;
    drive(1, 1, 3'd1, 4'd3, 4'd9);
    tests_run++;
    if (o_stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_stall: got %b want 0", o_stall);
    end
    tick(); idle();
    for (int c = 0; c < 12; c++) begin
      tests_run++;
      if (o_wr_en !== 1'b0 || o_busy !== 8'h00) begin
        tests_failed++;
        $display("FAIL flush_c%0d: wr_en=%b busy=%h want 0/00", c, o_wr_en, o_busy);
      end
      tick();
    end
    $display("[TB] flush done");
  endtask

  task automatic test_async_reset();
    drive(1, 1, 3'd2, 4'd4, 4'd5); tick();
    drive(1, 1, 3'd3, 4'd6, 4'd7); tick();
    drive(1, 1, 3'd1, 4'd1, 4'd9); tick();
    idle();
    tests_run++;
    if (o_wr_en !== 1'b1 || o_wr_addr !== 3'd1 || o_wr_src !== 4'd9 || o_busy !== 8'h0E) begin
      tests_failed++;
      $display("FAIL rst_pre: wr_en=%b addr=%0d src=%0d busy=%h want 1/1/9/0e", o_wr_en, o_wr_addr, o_wr_src, o_busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (o_wr_en !== 1'b0 || o_wr_addr !== 3'd0 || o_wr_src !== 4'd0 || o_busy !== 8'h00) begin
      tests_failed++;
      $display("FAIL rst_async: wr_en=%b addr=%0d src=%0d busy=%h want 0/0/0/00", o_wr_en, o_wr_addr, o_wr_src, o_busy);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int c = 0; c < 10; c++) begin
      tests_run++;
      if (o_wr_en !== 1'b0 || o_busy !== 8'h00) begin
        tests_failed++;
        $display("FAIL rst_after_c%0d: wr_en=%b busy=%h want 0/00", c, o_wr_en, o_busy);
      end
      tick();
    end
    $display("[TB] async reset done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_conflict();
    test_reservation();
    test_back_to_back();
    test_non_a();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
